i2c_user_frontend: RTL and testbench

Front-end stage between the board's raw buttons/switches and the I2C EEPROM controller. Debounces the request and write-select buttons and synchronises the address/data switches. Converts each button press into exactly one single-cycle `newd` request with stable operands, then waits for the controller's `done`. Latches read data for the LEDs and flags a transaction that never completes.

---
 rtl/i2c_fe_pkg.sv | 19 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/i2c_user_frontend.sv | 188 ++++++++++++++++++
 tb/tb_i2c_user_frontend.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_fe_pkg.sv
// Shared types and sizing helpers for the I2C user front-end.
package i2c_fe_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } fe_state_t;

    // Bits needed for a counter that must be able to hold max_count itself.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-counter debouncer and a
// registered one-cycle rising-edge pulse of the debounced level.
module btn_debounce
    import i2c_fe_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = cnt_width(DB_CYCLES);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;

    // Level flips only after DB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/i2c_user_frontend.sv
// Buttons/switches to I2C EEPROM controller request front-end.
// Optional WAIT timeout and ERR state built when I2C_FE_TIMEOUT_EN is defined.
module i2c_user_frontend
    import i2c_fe_pkg::*;
#(
    parameter int DB_CYCLES      = 1_000_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_newd_btn,
    input  logic              i_wr_btn,
    input  logic [DATA_W-1:0] i_wdata_sw,
    input  logic [ADDR_W-1:0] i_addr_sw,
    output logic              o_newd,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_done,
    output logic [DATA_W-1:0] o_rdata_led,
    output logic              o_busy,
    output logic              o_err
);

    if (DB_CYCLES < 2) begin : g_db_check
        $error("DB_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_to_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic              w_req_rise;
    logic              w_unused_req_level;
    logic              w_wr_level;
    logic              w_unused_wr_rise;

    logic [ADDR_W-1:0] r_addr_meta;
    logic [ADDR_W-1:0] r_addr_sync;
    logic [DATA_W-1:0] r_wdata_meta;
    logic [DATA_W-1:0] r_wdata_sync;

    fe_state_t         r_state;
    fe_state_t         w_state_nxt;
    logic              w_launch;
    logic              w_complete;

    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_led;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_req_db (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_newd_btn),
        .o_level (w_unused_req_level),
        .o_rise  (w_req_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_wr_db (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_wr_btn),
        .o_level (w_wr_level),
        .o_rise  (w_unused_wr_rise)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr_meta  <= '0;
            r_addr_sync  <= '0;
            r_wdata_meta <= '0;
            r_wdata_sync <= '0;
        end else begin
            r_addr_meta  <= i_addr_sw;
            r_addr_sync  <= r_addr_meta;
            r_wdata_meta <= i_wdata_sw;
            r_wdata_sync <= r_wdata_meta;
        end
    end

`ifdef I2C_FE_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_to_expire;

    // Expires at the end of the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_to_expire = (r_state == ST_WAIT) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_REQ) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT && r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_complete) begin
            r_err <= 1'b0;
        end else if (r_state == ST_WAIT && w_state_nxt == ST_ERR) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_rise) begin
                    w_state_nxt = ST_REQ;
                    w_launch    = 1'b1;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over a simultaneous timeout.
                if (i_done) begin
                    w_state_nxt = ST_IDLE;
                    w_complete  = 1'b1;
                end
`ifdef I2C_FE_TIMEOUT_EN
                else if (w_to_expire) begin
                    w_state_nxt = ST_ERR;
                end
`endif
            end
            ST_ERR: begin
                if (w_req_rise) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata_led <= '0;
        end else begin
            if (w_launch) begin
                r_wr    <= w_wr_level;
                r_addr  <= r_addr_sync;
                r_wdata <= r_wdata_sync;
            end
            if (w_complete && !r_wr) begin
                r_rdata_led <= i_rdata;
            end
        end
    end

    assign o_newd      = (r_state == ST_REQ);
    assign o_busy      = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign o_wr        = r_wr;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_rdata_led = r_rdata_led;

endmodule

// File: tb/tb_i2c_user_frontend.sv
// Directed bench for i2c_user_frontend (DB_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_i2c_user_frontend;

    localparam int DB  = 4;
    localparam int TO  = 50;
    localparam int LAT = DB + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       newd_btn = 1'b0;
    logic       wr_btn = 1'b0;
    logic       done = 1'b0;
    logic [7:0] wdata_sw = '0;
    logic [6:0] addr_sw = '0;
    logic [7:0] rdata = '0;

    logic       o_newd;
    logic       o_wr;
    logic [7:0] o_wdata;
    logic [6:0] o_addr;
    logic [7:0] o_rdata_led;
    logic       o_busy;
    logic       o_err;

    int errors = 0;
    int checks = 0;

    i2c_user_frontend #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_newd_btn  (newd_btn),
        .i_wr_btn    (wr_btn),
        .i_wdata_sw  (wdata_sw),
        .i_addr_sw   (addr_sw),
        .o_newd      (o_newd),
        .o_wr        (o_wr),
        .o_wdata     (o_wdata),
        .o_addr      (o_addr),
        .i_rdata     (rdata),
        .i_done      (done),
        .o_rdata_led (o_rdata_led),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       wrb;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [7:0] expLed;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wrb, input logic [6:0] a, input logic [7:0] wd);
        wr_btn   = wrb;
        addr_sw  = a;
        wdata_sw = wd;
        tick(DB + 6);
    endtask

    // Holds the request button and returns the cycle count to the first newd (-1 if none).
    task automatic pressButton(output int lat);
        newd_btn = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (o_newd) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic countNewd(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= n; c++) begin
            tick(1);
            if (o_newd) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
    endtask

    task automatic driveDone(input logic [7:0] rd);
        done  = 1'b1;
        rdata = rd;
        tick(1);
        done  = 1'b0;
        rdata = '0;
    endtask

    initial begin
        int lat;
        int pulses;
        int first;
        int bounce;

        vecs[0] = '{"read15",  1'b0, 7'h15, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{"write01", 1'b1, 7'h01, 8'h3C, 8'h5A, 8'hA5};
        vecs[2] = '{"read7f",  1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{"write40", 1'b1, 7'h40, 8'h81, 8'hFF, 8'h00};
        vecs[4] = '{"read2a",  1'b0, 7'h2A, 8'h00, 8'hC3, 8'hC3};

        @(negedge clk);
        tick(3);
        rst = 1'b0;
        checkOutput("reset_newd", o_newd, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_err", o_err, 0);
        checkOutput("reset_led", o_rdata_led, 0);
        checkOutput("reset_addr", o_addr, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].wrb, vecs[i].addr, vecs[i].wdata);
            pressButton(lat);
            checkOutput({vecs[i].name, "_latency"}, lat, LAT);
            checkOutput({vecs[i].name, "_wr"}, o_wr, vecs[i].wrb);
            checkOutput({vecs[i].name, "_addr"}, o_addr, vecs[i].addr);
            checkOutput({vecs[i].name, "_wdata"}, o_wdata, vecs[i].wdata);
            checkOutput({vecs[i].name, "_busy_req"}, o_busy, 1);
            tick(1);
            checkOutput({vecs[i].name, "_newd_single"}, o_newd, 0);
            newd_btn = 1'b0;
            addr_sw  = ~vecs[i].addr;
            wdata_sw = ~vecs[i].wdata;
            tick(3);
            checkOutput({vecs[i].name, "_busy_wait"}, o_busy, 1);
            driveDone(vecs[i].rdata);
            checkOutput({vecs[i].name, "_led"}, o_rdata_led, vecs[i].expLed);
            checkOutput({vecs[i].name, "_busy_done"}, o_busy, 0);
            checkOutput({vecs[i].name, "_addr_hold"}, o_addr, vecs[i].addr);
            tick(DB + 6);
        end

        $display("[TB] bounce sequence");
        applyStimulus(1'b0, 7'h0B, 8'h00);
        bounce = 0;
        for (int i = 0; i < 10; i++) begin
            newd_btn = ~newd_btn;
            countNewd(2, pulses, first);
            bounce += pulses;
        end
        newd_btn = 1'b1;
        countNewd(20, pulses, first);
        checkOutput("bounce_pulse_count", bounce + pulses, 1);
        checkOutput("bounce_latency", first, LAT);
        newd_btn = 1'b0;
        driveDone(8'h77);
        checkOutput("bounce_led", o_rdata_led, 8'h77);
        checkOutput("bounce_addr", o_addr, 7'h0B);
        tick(DB + 6);

        $display("[TB] press while busy");
        applyStimulus(1'b0, 7'h33, 8'h00);
        pressButton(lat);
        checkOutput("busy_drop_latency", lat, LAT);
        tick(1);
        newd_btn = 1'b0;
        tick(DB + 6);
        newd_btn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            addr_sw = addr_sw + 7'd1;
            tick(1);
            if (o_newd) pulses++;
        end
        checkOutput("busy_drop_no_newd", pulses, 0);
        checkOutput("busy_drop_addr", o_addr, 7'h33);
        checkOutput("busy_drop_busy", o_busy, 1);
        driveDone(8'h5E);
        checkOutput("busy_drop_led", o_rdata_led, 8'h5E);
        countNewd(15, pulses, first);
        checkOutput("held_no_repeat", pulses, 0);
        newd_btn = 1'b0;
        tick(DB + 6);

`ifdef I2C_FE_TIMEOUT_EN
        $display("[TB] timeout sequence");
        applyStimulus(1'b0, 7'h22, 8'h00);
        pressButton(lat);
        checkOutput("timeout_latency", lat, LAT);
        newd_btn = 1'b0;
        tick(TO);
        checkOutput("timeout_err_early", o_err, 0);
        checkOutput("timeout_busy_early", o_busy, 1);
        tick(1);
        checkOutput("timeout_err_set", o_err, 1);
        checkOutput("timeout_busy_clear", o_busy, 0);
        tick(DB + 6);
        newd_btn = 1'b1;
        countNewd(20, pulses, first);
        checkOutput("err_press_no_newd", pulses, 0);
        checkOutput("err_sticky", o_err, 1);
        newd_btn = 1'b0;
        tick(DB + 6);
        pressButton(lat);
        checkOutput("after_err_latency", lat, LAT);
        newd_btn = 1'b0;
        tick(2);
        driveDone(8'h99);
        checkOutput("after_err_clear", o_err, 0);
        checkOutput("after_err_led", o_rdata_led, 8'h99);
        tick(DB + 6);
`else
        $display("[TB] no-timeout sequence");
        applyStimulus(1'b0, 7'h22, 8'h00);
        pressButton(lat);
        checkOutput("notimeout_latency", lat, LAT);
        newd_btn = 1'b0;
        tick(TO + 10);
        checkOutput("notimeout_err", o_err, 0);
        checkOutput("notimeout_busy", o_busy, 1);
        driveDone(8'h99);
        checkOutput("notimeout_busy_done", o_busy, 0);
        checkOutput("notimeout_led", o_rdata_led, 8'h99);
        tick(DB + 6);
`endif

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 7'h6C, 8'hE7);
        pressButton(lat);
        checkOutput("rst_seq_latency", lat, LAT);
        newd_btn = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rst_newd", o_newd, 0);
        checkOutput("rst_wr", o_wr, 0);
        checkOutput("rst_addr", o_addr, 0);
        checkOutput("rst_wdata", o_wdata, 0);
        checkOutput("rst_led", o_rdata_led, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_err", o_err, 0);
        tick(DB + 6);
        applyStimulus(1'b0, 7'h12, 8'h00);
        pressButton(lat);
        checkOutput("post_rst_latency", lat, LAT);
        checkOutput("post_rst_addr", o_addr, 7'h12);
        checkOutput("post_rst_wr", o_wr, 0);
        newd_btn = 1'b0;
        tick(2);
        driveDone(8'h4D);
        checkOutput("post_rst_led", o_rdata_led, 8'h4D);
        checkOutput("post_rst_busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
